// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Registered output stage behind the ALU result mux bank. Captures the
//   selected result and its 3-bit op code, derives {Z,N,C,V}, and buffers up
//   to two completed operations in a 2-entry FIFO with a valid/ready handshake
//   toward the consumer. Keeps a wrapping count of delivered results.
//
// Ports
//   CLK, RST_N            clock, async active-low reset
//   IN_VALID / IN_READY   upstream handshake (IN_READY is registered)
//   SEL, RESULT           op code and mux bank output
//   CARRY_IN, OVF_IN      adder carry/borrow and signed overflow
//   OUT_VALID / OUT_READY downstream handshake
//   OUT_RESULT, OUT_SEL   head entry result and op code
//   FLAGS                 head entry flags {Z,N,C,V}
//   OP_COUNT              completed output transfers, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       SEL,
    input  logic [WIDTH-1:0] RESULT,
    input  logic             CARRY_IN,
    input  logic             OVF_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_RESULT,
    output logic [2:0]       OUT_SEL,
    output logic [3:0]       FLAGS,
    output logic [CNT_W-1:0] OP_COUNT
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [2:0]       sel;
        logic [3:0]       flags;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // e0 is always the head; e1 only holds the second entry when full.
    entry_t     e0, e1, new_e;
    logic [1:0] count, count_nxt;
    logic       in_rdy_q;
    logic       push, pop, arith;
    logic [CNT_W-1:0] op_cnt;

    assign push  = IN_VALID & in_rdy_q;
    assign pop   = (count != 2'd0) & OUT_READY;

    // Carry and overflow are only meaningful for ADD (0) and SUB (1).
    assign arith = (SEL[2:1] == 2'b00);

    always_comb begin
        new_e       = '0;
        new_e.res   = RESULT;
        new_e.sel   = SEL;
        new_e.flags = {(RESULT == '0), RESULT[WIDTH-1], arith & CARRY_IN, arith & OVF_IN};
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            e0       <= '0;
            e1       <= '0;
            count    <= 2'd0;
            in_rdy_q <= 1'b0;
            op_cnt   <= '0;
        end else begin
            count    <= count_nxt;
            in_rdy_q <= (count_nxt < 2'd2);
            if (pop)
                op_cnt <= op_cnt + CNT_ONE;

            // Push cannot coincide with count==2 because IN_READY is low then.
            // A pop at count==1 without a push leaves e0 untouched so the
            // outputs keep showing the last-popped entry while empty.
            if (pop) begin
                if (count == 2'd2)
                    e0 <= e1;
                else if (push)
                    e0 <= new_e;
            end else if (push) begin
                if (count == 2'd0)
                    e0 <= new_e;
                else
                    e1 <= new_e;
            end
        end
    end

    assign IN_READY   = in_rdy_q;
    assign OUT_VALID  = (count != 2'd0);
    assign OUT_RESULT = e0.res;
    assign OUT_SEL    = e0.sel;
    assign FLAGS      = e0.flags;
    assign OP_COUNT   = op_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             IN_VALID;
    logic             IN_READY;
    logic [2:0]       SEL;
    logic [WIDTH-1:0] RESULT;
    logic             CARRY_IN;
    logic             OVF_IN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_RESULT;
    logic [2:0]       OUT_SEL;
    logic [3:0]       FLAGS;
    logic [CNT_W-1:0] OP_COUNT;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .SEL(SEL), .RESULT(RESULT), .CARRY_IN(CARRY_IN), .OVF_IN(OVF_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_RESULT(OUT_RESULT), .OUT_SEL(OUT_SEL), .FLAGS(FLAGS),
        .OP_COUNT(OP_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [2:0]       sel;
        logic [WIDTH-1:0] res;
        logic             cin;
        logic             ovf;
        logic [3:0]       flags;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        exp_cnt = 0;
    endtask

    task automatic one_xfer(input logic [WIDTH-1:0] r);
        IN_VALID = 1'b1; RESULT = r; SEL = 3'd3; OUT_READY = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'd0, 4'h0, 1'b1, 1'b1, 4'b1011};
        vecs[1] = '{3'd2, 4'h9, 1'b1, 1'b0, 4'b0100};
        vecs[2] = '{3'd1, 4'hF, 1'b1, 1'b0, 4'b0110};
        vecs[3] = '{3'd4, 4'h0, 1'b1, 1'b1, 4'b1000};
        vecs[4] = '{3'd0, 4'h7, 1'b0, 1'b1, 4'b0001};
        vecs[5] = '{3'd7, 4'h8, 1'b0, 1'b1, 4'b0100};
        vecs[6] = '{3'd6, 4'h6, 1'b1, 1'b1, 4'b0000};

        // 1. reset / idle with IN_VALID held high
        RST_N = 1'b0; IN_VALID = 1'b1; SEL = 3'd0; RESULT = 4'h5;
        CARRY_IN = 1'b0; OVF_IN = 1'b0; OUT_READY = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
            chk("rst_op_count", 32'(OP_COUNT), 32'd0);
            chk("rst_flags", 32'(FLAGS), 32'd0);
            chk("rst_in_ready", 32'(IN_READY), 32'd0);
            tick();
        end
        RST_N = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", 32'(IN_READY), 32'd0);
        tick();
        chk("rel_in_ready_after_edge", 32'(IN_READY), 32'd1);
        chk("rel_no_push", 32'(OUT_VALID), 32'd0);
        IN_VALID = 1'b0;

        // 2. single transfers and flags
        foreach (vecs[i]) begin
            IN_VALID = 1'b1; SEL = vecs[i].sel; RESULT = vecs[i].res;
            CARRY_IN = vecs[i].cin; OVF_IN = vecs[i].ovf; OUT_READY = 1'b1;
            tick();
            IN_VALID = 1'b0;
            chk("vec_out_valid", 32'(OUT_VALID), 32'd1);
            chk("vec_out_result", 32'(OUT_RESULT), 32'(vecs[i].res));
            chk("vec_out_sel", 32'(OUT_SEL), 32'(vecs[i].sel));
            chk("vec_flags", 32'(FLAGS), 32'(vecs[i].flags));
            tick();
            exp_cnt++;
            chk("vec_op_count", 32'(OP_COUNT), 32'(exp_cnt));
            chk("vec_empty", 32'(OUT_VALID), 32'd0);
            chk("vec_hold_result", 32'(OUT_RESULT), 32'(vecs[i].res));
            chk("vec_hold_flags", 32'(FLAGS), 32'(vecs[i].flags));
        end

        // 3. backpressure / full
        CARRY_IN = 1'b0; OVF_IN = 1'b0; SEL = 3'd3;
        OUT_READY = 1'b0; IN_VALID = 1'b1; RESULT = 4'h3;
        tick();
        chk("bp_in_ready_1", 32'(IN_READY), 32'd1);
        RESULT = 4'h5;
        tick();
        chk("bp_in_ready_full", 32'(IN_READY), 32'd0);
        chk("bp_head_3", 32'(OUT_RESULT), 32'h3);
        RESULT = 4'h7;
        tick();
        chk("bp_still_full", 32'(IN_READY), 32'd0);
        chk("bp_head_hold", 32'(OUT_RESULT), 32'h3);
        chk("bp_count_hold", 32'(OP_COUNT), 32'(exp_cnt));
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_head_5", 32'(OUT_RESULT), 32'h5);
        chk("bp_valid_5", 32'(OUT_VALID), 32'd1);
        chk("bp_in_ready_back", 32'(IN_READY), 32'd1);
        tick();
        exp_cnt++;
        chk("bp_drained", 32'(OUT_VALID), 32'd0);
        chk("bp_last_5", 32'(OUT_RESULT), 32'h5);
        chk("bp_count", 32'(OP_COUNT), 32'(exp_cnt));

        // 4. simultaneous push and pop at count=1
        OUT_READY = 1'b0; IN_VALID = 1'b1; RESULT = 4'hA;
        tick();
        chk("pp_head_a", 32'(OUT_RESULT), 32'hA);
        RESULT = 4'hB; OUT_READY = 1'b1;
        tick();
        exp_cnt++;
        IN_VALID = 1'b0;
        chk("pp_valid", 32'(OUT_VALID), 32'd1);
        chk("pp_head_b", 32'(OUT_RESULT), 32'hB);
        chk("pp_in_ready", 32'(IN_READY), 32'd1);
        tick();
        exp_cnt++;
        chk("pp_count_was_1", 32'(OUT_VALID), 32'd0);
        chk("pp_op_count", 32'(OP_COUNT), 32'(exp_cnt));

        // 5. counter wrap
        OUT_READY = 1'b0;
        do_reset();
        chk("wrap_start", 32'(OP_COUNT), 32'd0);
        for (int i = 0; i < 255; i++) one_xfer(4'(i));
        chk("wrap_255", 32'(OP_COUNT), 32'd255);
        one_xfer(4'h1);
        chk("wrap_0", 32'(OP_COUNT), 32'd0);
        one_xfer(4'h2);
        chk("wrap_1", 32'(OP_COUNT), 32'd1);

        // 6. async reset mid-stream with two entries buffered
        OUT_READY = 1'b0; IN_VALID = 1'b1; RESULT = 4'hC;
        tick();
        RESULT = 4'hD;
        tick();
        IN_VALID = 1'b0;
        chk("ar_full", 32'(IN_READY), 32'd0);
        chk("ar_valid_before", 32'(OUT_VALID), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_valid_async", 32'(OUT_VALID), 32'd0);
        chk("ar_count_async", 32'(OP_COUNT), 32'd0);
        chk("ar_result_async", 32'(OUT_RESULT), 32'd0);
        #2;
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        tick();
        chk("ar_in_ready", 32'(IN_READY), 32'd1);
        chk("ar_no_stale", 32'(OUT_VALID), 32'd0);
        tick();
        chk("ar_no_stale_2", 32'(OUT_VALID), 32'd0);
        chk("ar_count_after", 32'(OP_COUNT), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage that sits directly downstream of the ALU result multiplexer bank, a WIDTH-wide bank of Mux_8a1 slices sharing one SEL.
- Captures the selected result together with its 3-bit operation code, and derives the Z/N/C/V status flags.
- Buffers up to two completed operations in a 2-entry FIFO with a valid/ready handshake toward the consumer (register file / display logic).
- Keeps a wrapping count of delivered results.

Parameters:
- WIDTH, 4, width of the ALU result (number of Mux_8a1 slices feeding this stage).
- CNT_W, 8, width of OP_COUNT.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream has a result on RESULT/SEL this cycle.
- IN_READY  out  1  stage can accept an entry this cycle.
- SEL  in  3  operation code that drove the mux (0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=NOT, 6=SHL, 7=SHR).
- RESULT  in  WIDTH  mux bank output.
- CARRY_IN  in  1  adder carry/borrow for the current operation.
- OVF_IN  in  1  adder signed overflow for the current operation.
- OUT_VALID  out  1  head entry is valid.
- OUT_READY  in  1  consumer accepts the head entry.
- OUT_RESULT  out  WIDTH  head entry result.
- OUT_SEL  out  3  head entry operation code.
- FLAGS  out  4  head entry flags {Z,N,C,V}, bit 3 = Z.
- OP_COUNT  out  CNT_W  number of completed output transfers, modulo 2^CNT_W.

Behaviour:
- Clock and reset: single clock domain (CLK). Reset is asynchronous and active-low (RST_N). While RST_N=0:
  - FIFO empties; both entries are cleared to 0.
  - OUT_VALID=0, OUT_RESULT=0, OUT_SEL=0, FLAGS=0, OP_COUNT=0.
  - IN_READY=0 during reset; IN_READY=1 on the first edge after release.
- Push: fires on a rising edge when IN_VALID & IN_READY. The entry stores RESULT, SEL and flags computed from the inputs in that cycle:
  - Z = (RESULT == 0).
  - N = RESULT[WIDTH-1].
  - C = CARRY_IN if SEL is 0 or 1; otherwise 0.
  - V = OVF_IN if SEL is 0 or 1; otherwise 0.
- Pop: fires on a rising edge when OUT_VALID & OUT_READY. It removes the head entry and increments OP_COUNT by 1, wrapping from 2^CNT_W-1 to 0.
- Output latency: an entry pushed into an empty FIFO appears on OUT_* on the next cycle, with OUT_VALID=1. There is no combinational input-to-output bypass.
- Ordering: strict FIFO. OUT_* always reflect the head entry. OUT_* hold stable while OUT_VALID=1 and OUT_READY=0.
- Occupancy count (0..2):
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
- IN_READY is registered and equals (count < 2) after each edge. It never depends combinationally on OUT_READY.
- Full (count=2): IN_READY=0, and IN_VALID is ignored. A pop in that cycle sets count to 1 and IN_READY to 1 on the next cycle.
- Empty (count=0): OUT_VALID=0, and OUT_READY is ignored. OUT_RESULT, OUT_SEL and FLAGS keep their last-popped values; after reset they are 0.
- Simultaneous push and pop at count=1: the head leaves, the new entry becomes the head on the next cycle, and OUT_VALID stays 1.
- Upstream rule: while IN_VALID=1 and IN_READY=0, the producer holds SEL, RESULT, CARRY_IN and OVF_IN stable. The stage does not check this.
- Reset mid-operation: asserting RST_N low in any cycle discards all buffered entries immediately and asynchronously, and clears OP_COUNT. No partial transfer completes on that edge.
- No error or overflow state exists; a push cannot be lost because IN_READY gates it.

Test Plan:
1. Reset / idle: hold RST_N=0 for 3 cycles with IN_VALID=1, then release. Required: OUT_VALID=0, OP_COUNT=0 and FLAGS=0 throughout reset; IN_READY=0 in reset and 1 after the first edge.
2. Single transfer and flags (WIDTH=4, OUT_READY=1):
   - Push SEL=0, RESULT=4'h0, CARRY_IN=1, OVF_IN=1 -> next cycle OUT_RESULT=0, FLAGS=4'b1011, then OP_COUNT=1.
   - Push SEL=2, RESULT=4'h9, CARRY_IN=1 -> FLAGS=4'b0100 (C and V masked).
3. Backpressure / full: OUT_READY=0, push results 4'h3, 4'h5, 4'h7 on consecutive cycles. Required:
   - Only 3 and 5 are accepted; IN_READY=0 after the second push.
   - OUT_RESULT holds 3.
   - Raising OUT_READY delivers 3 then 5, and IN_READY returns to 1 one cycle after the first pop.
4. Simultaneous push and pop at count=1: with entry 4'hA buffered, OUT_READY=1 and push 4'hB in the same cycle. Required: next cycle OUT_VALID=1, OUT_RESULT=4'hB, count remains 1.
5. Counter wrap (CNT_W=8): perform 257 transfers. Required: OP_COUNT reads 255, then 0, then 1.
6. Async reset mid-stream: with 2 entries buffered, pulse RST_N low between clock edges. Required: OUT_VALID and OP_COUNT go to 0 without waiting for a CLK edge; no stale entry appears after release.
